// File: rtl/fifo_line_reader.sv
// fifo_line_reader: drains the line FIFO into a valid/ready pixel stream,
// hiding FIFO read latency behind a credit-controlled skid buffer.
//
// Ports:
//   CLK, RESET          clock, async active-high reset
//   EN                  1 = fetch from FIFO, 0 = stop fetching and drain
//   FIFO_EMPTY, FIFO_Q  FIFO status and read data (RD_LATENCY after FIFO_RE)
//   FIFO_RE             FIFO read enable, one word per cycle
//   M_VALID/M_READY     output handshake, M_DATA is the skid head word
//   M_SOL, M_EOL        head word is first / last word of a line
//   LINE_CNT            completed lines since reset (wraps)
//   BUSY                controller not idle
module fifo_line_reader #(
    parameter int DW         = 32,
    parameter int RD_LATENCY = 2,
    parameter int SKID_DEPTH = 4,
    parameter int LINE_WORDS = 480
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          EN,
    input  logic          FIFO_EMPTY,
    input  logic [DW-1:0] FIFO_Q,
    output logic          FIFO_RE,
    output logic          M_VALID,
    input  logic          M_READY,
    output logic [DW-1:0] M_DATA,
    output logic          M_SOL,
    output logic          M_EOL,
    output logic [15:0]   LINE_CNT,
    output logic          BUSY
);

    localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int CW = $clog2(2 * SKID_DEPTH + 1);
    localparam int IW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t state, state_nxt;

    logic [RD_LATENCY-1:0] re_pipe;
    logic [DW-1:0]         skid [SKID_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         occ;
    logic [CW-1:0]         inflight;
    logic [IW-1:0]         word_idx;
    logic                  push;
    logic                  pop;
    logic                  pending;
    logic                  credit_ok;
    logic                  head_eol;

    // The tap of the read-enable shadow marks the cycle FIFO_Q is valid.
    assign push      = re_pipe[RD_LATENCY-1];
    assign pop       = M_VALID & M_READY;
    assign pending   = (inflight != '0) | (occ != '0);
    // Every issued read reserves a skid slot, so landing data always fits.
    assign credit_ok = (inflight + occ) < CW'(SKID_DEPTH);
    assign FIFO_RE   = ~RESET & EN & ~FIFO_EMPTY & credit_ok & (state != DRAIN);

    assign head_eol = (word_idx == IW'(LINE_WORDS - 1));
    assign M_VALID  = (occ != '0);
    assign M_DATA   = M_VALID ? skid[rd_ptr] : '0;
    assign M_SOL    = M_VALID & (word_idx == '0);
    assign M_EOL    = M_VALID & head_eol;
    assign BUSY     = (state != IDLE);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            re_pipe  <= '0;
            inflight <= '0;
            occ      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            word_idx <= '0;
            LINE_CNT <= '0;
        end else begin
            state    <= state_nxt;
            re_pipe  <= (re_pipe << 1) | RD_LATENCY'(FIFO_RE);
            inflight <= inflight + CW'(FIFO_RE) - CW'(push);
            occ      <= occ + CW'(push) - CW'(pop);
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(SKID_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(SKID_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
                if (head_eol) begin
                    word_idx <= '0;
                    LINE_CNT <= LINE_CNT + 16'd1;
                end else begin
                    word_idx <= word_idx + IW'(1);
                end
            end
        end
    end

    // Storage needs no reset: M_VALID gates everything read from it.
    always_ff @(posedge CLK) begin
        if (push) begin
            skid[wr_ptr] <= FIFO_Q;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (EN) state_nxt = RUN;
            end
            RUN: begin
                if (!EN) state_nxt = pending ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (EN)            state_nxt = RUN;
                else if (!pending) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    skid_no_overflow: assert property (
        @(posedge CLK) disable iff (RESET)
        !(push && !pop && (occ == CW'(SKID_DEPTH)))
    );

endmodule
